bus_width_increase_arbiter: RTL and testbench

- Shares one bus_width_increase packer (SIZE_IN to SIZE_OUT) between N narrow requesters.
- Grants one requester at a time. The grant is locked for exactly RATIO = SIZE_OUT/SIZE_IN accepted beats, so output words never interleave sources.
- Tags each completed word with its owner.
- Pads a word with PAD_VALUE beats when the owner stalls mid-word longer than TIMEOUT cycles.
- Sits between requester FIFOs and the packer's valid_in/data_in.

---
 rtl/bus_width_increase_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_bus_width_increase_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_width_increase_arbiter.sv
// -----------------------------------------------------------------------------
// bus_width_increase_arbiter
//
// Shares one SIZE_IN -> SIZE_OUT width-increase packer between N narrow
// requesters. A requester is granted for a whole packer word, i.e. exactly
// RATIO = SIZE_OUT/SIZE_IN accepted beats, so output words never mix sources.
// Grants rotate round-robin starting after the owner of the last finished
// word. If the owner stalls mid-word for TIMEOUT cycles the rest of the word
// is filled with PAD_VALUE beats so the packer is never left half full.
// TIMEOUT = 0 disables padding (the owner may stall forever).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   req_valid    [N]            per-requester beat valid
//   req_data     [N*SIZE_IN]    requester i on bits [i*SIZE_IN +: SIZE_IN]
//   req_ready    [N]            per-requester accept (one-hot or zero),
//                               combinational from state only
//   pk_valid     registered packer valid_in
//   pk_data      [SIZE_IN]      registered packer data_in
//   word_owner   [OW]           registered owner of the current/last word
//   word_done    registered, high with the final beat of a word
//   word_padded  registered, high with word_done when the word held pads
//
// The packer must share this reset: a mid-word reset drops the partial word
// here and the arbiter does not compensate for any packer fill.
// -----------------------------------------------------------------------------
module bus_width_increase_arbiter #(
    parameter int                N         = 4,
    parameter int                SIZE_IN   = 8,
    parameter int                SIZE_OUT  = 32,
    parameter int                TIMEOUT   = 16,
    parameter logic [SIZE_IN-1:0] PAD_VALUE = '0,
    localparam int               OW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req_valid,
    input  logic [N*SIZE_IN-1:0]  req_data,
    output logic [N-1:0]          req_ready,
    output logic                  pk_valid,
    output logic [SIZE_IN-1:0]    pk_data,
    output logic [OW-1:0]         word_owner,
    output logic                  word_done,
    output logic                  word_padded
);

    localparam int          RATIO = SIZE_OUT / SIZE_IN;
    localparam int          BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int          IW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned NU    = N;

    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        PAD    = 2'd2
    } state_t;

    state_t          state;
    logic [OW-1:0]   grant;
    logic [OW-1:0]   last_owner;
    logic [BW-1:0]   beat_cnt;
    logic [IW-1:0]   idle_cnt;

    logic               sel_valid;
    logic [SIZE_IN-1:0] sel_data;
    logic               any_valid;
    logic               last_beat;
    logic [OW-1:0]      pick_from_last;
    logic [OW-1:0]      pick_from_grant;

    // Round-robin search: first asserted request strictly after 'base',
    // wrapping modulo N. Returns 'base' when nothing is asserted.
    function automatic logic [OW-1:0] rr_pick(input logic [OW-1:0] base,
                                              input logic [N-1:0]  vec);
        logic [OW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = base;
        found = 1'b0;
        for (int unsigned step = 1; step <= NU; step++) begin
            idx = 32'(base) + step;
            if (idx >= NU) begin
                idx = idx - NU;
            end
            if (!found && vec[idx[OW-1:0]]) begin
                found = 1'b1;
                pick  = idx[OW-1:0];
            end
        end
        return pick;
    endfunction

    // Granted requester's valid/data and the ready vector. Ready depends on
    // state only, so it is one-hot while LOCKED and zero in IDLE/PAD.
    always_comb begin
        req_ready = '0;
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (grant == OW'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*SIZE_IN +: SIZE_IN];
                if (state == LOCKED) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    assign any_valid       = |req_valid;
    assign last_beat       = (beat_cnt == LAST_BEAT);
    assign pick_from_last  = rr_pick(last_owner, req_valid);
    assign pick_from_grant = rr_pick(grant, req_valid);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= '0;
            last_owner  <= OW'(N - 1);
            beat_cnt    <= '0;
            idle_cnt    <= '0;
            pk_valid    <= 1'b0;
            pk_data     <= '0;
            word_owner  <= '0;
            word_done   <= 1'b0;
            word_padded <= 1'b0;
        end else begin
            // Strobes default low; pk_data and word_owner hold between beats.
            pk_valid    <= 1'b0;
            word_done   <= 1'b0;
            word_padded <= 1'b0;

            unique case (state)
                IDLE: begin
                    // One bubble cycle: choose an owner, accept nothing yet.
                    beat_cnt <= '0;
                    idle_cnt <= '0;
                    if (any_valid) begin
                        grant <= pick_from_last;
                        state <= LOCKED;
                    end
                end

                LOCKED: begin
                    if (sel_valid) begin
                        // An accept always wins over the timeout decision.
                        pk_valid   <= 1'b1;
                        pk_data    <= sel_data;
                        word_owner <= grant;
                        idle_cnt   <= '0;
                        if (last_beat) begin
                            word_done  <= 1'b1;
                            beat_cnt   <= '0;
                            last_owner <= grant;
                            // Back-to-back words: re-arbitrate from the
                            // finishing owner without an IDLE bubble.
                            if (any_valid) begin
                                grant <= pick_from_grant;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (beat_cnt == '0) begin
                        // Owner withdrew before its first beat: release.
                        state <= IDLE;
                    end else if (TIMEOUT > 0) begin
                        if (idle_cnt == IDLE_MAX) begin
                            idle_cnt <= '0;
                            state    <= PAD;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end

                PAD: begin
                    pk_valid   <= 1'b1;
                    pk_data    <= PAD_VALUE;
                    word_owner <= grant;
                    if (last_beat) begin
                        word_done   <= 1'b1;
                        word_padded <= 1'b1;
                        last_owner  <= grant;
                        beat_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_width_increase_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for bus_width_increase_arbiter. Two instances run side by side, one
// with TIMEOUT=16 (index 0) and one with TIMEOUT=0 (index 1), each fed by its
// own set of per-requester byte queues. A cycle-level model predicts every
// output and is compared on each falling edge; directed scenarios add
// hand-computed literal expectations on assembled words and key cycles.
// -----------------------------------------------------------------------------
module tb_bus_width_increase_arbiter;

    localparam int N     = 4;
    localparam int SI    = 8;
    localparam int SO    = 32;
    localparam int RATIO = SO / SI;
    localparam logic [7:0] PADV = 8'h00;

    typedef struct {
        int          owner;
        logic [31:0] data;
        bit          padded;
        int          cyc;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]    vld [2];
    logic [N*SI-1:0] dat [2];
    logic [N-1:0]    rdy [2];
    logic            pkv [2];
    logic [7:0]      pkd [2];
    logic [1:0]      wo  [2];
    logic            wd  [2];
    logic            wp  [2];

    bus_width_increase_arbiter #(
        .N(N), .SIZE_IN(SI), .SIZE_OUT(SO), .TIMEOUT(16), .PAD_VALUE(PADV)
    ) dut_t16 (
        .clk(clk), .reset(rst_n),
        .req_valid(vld[0]), .req_data(dat[0]), .req_ready(rdy[0]),
        .pk_valid(pkv[0]), .pk_data(pkd[0]), .word_owner(wo[0]),
        .word_done(wd[0]), .word_padded(wp[0])
    );

    bus_width_increase_arbiter #(
        .N(N), .SIZE_IN(SI), .SIZE_OUT(SO), .TIMEOUT(0), .PAD_VALUE(PADV)
    ) dut_t0 (
        .clk(clk), .reset(rst_n),
        .req_valid(vld[1]), .req_data(dat[1]), .req_ready(rdy[1]),
        .pk_valid(pkv[1]), .pk_data(pkd[1]), .word_owner(wo[1]),
        .word_done(wd[1]), .word_padded(wp[1])
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requester byte queues and driver ----------------
    logic [7:0] mem [2][N][256];
    int         hd  [2][N];
    int         tl  [2][N];
    logic [N-1:0] en [2];

    task automatic push_both(input int i, input logic [7:0] b);
        for (int k = 0; k < 2; k++) begin
            mem[k][i][tl[k][i]] = b;
            tl[k][i]++;
        end
    endtask

    task automatic clear_queues();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                hd[k][i] = 0;
                tl[k][i] = 0;
            end
    endtask

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            logic [N-1:0]    v;
            logic [N*SI-1:0] d;
            v = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (hd[k][i] < tl[k][i]) begin
                    v[i] = en[k][i];
                    d[i*SI +: SI] = mem[k][i][hd[k][i]];
                end
            end
            vld[k] = v;
            dat[k] = d;
        end
    end

    // ---------------- behavioural model ----------------
    int  timeout_of [2] = '{16, 0};
    bit  m_active [2];
    bit  m_pad    [2];
    int  m_owner  [2];
    int  m_beats  [2];
    int  m_stall  [2];
    int  m_last   [2];
    bit  e_v      [2];
    logic [7:0] e_d [2];
    int  e_o      [2];
    bit  e_done   [2];
    bit  e_pd     [2];

    function automatic int rr_next(input int base, input logic [N-1:0] v);
        for (int d = 1; d <= N; d++)
            if (v[(base + d) % N]) return (base + d) % N;
        return base;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int k);
        logic [N-1:0] r;
        r = '0;
        if (m_active[k] && !m_pad[k]) r[m_owner[k]] = 1'b1;
        return r;
    endfunction

    task automatic model_step(input int k);
        logic [N-1:0]    v;
        logic [N*SI-1:0] d;
        v = vld[k];
        d = dat[k];
        if (!rst_n) begin
            m_active[k] = 0; m_pad[k] = 0; m_owner[k] = 0;
            m_beats[k] = 0; m_stall[k] = 0; m_last[k] = N - 1;
            e_v[k] = 0; e_d[k] = 8'h00; e_o[k] = 0; e_done[k] = 0; e_pd[k] = 0;
            return;
        end
        e_v[k] = 0; e_done[k] = 0; e_pd[k] = 0;
        if (m_pad[k]) begin
            e_v[k] = 1; e_d[k] = PADV; e_o[k] = m_owner[k];
            m_beats[k]++;
            if (m_beats[k] == RATIO) begin
                e_done[k] = 1; e_pd[k] = 1;
                m_last[k] = m_owner[k]; m_beats[k] = 0;
                m_pad[k] = 0; m_active[k] = 0;
            end
        end else if (m_active[k]) begin
            if (v[m_owner[k]]) begin
                e_v[k] = 1; e_d[k] = d[m_owner[k]*SI +: SI]; e_o[k] = m_owner[k];
                m_stall[k] = 0;
                m_beats[k]++;
                if (m_beats[k] == RATIO) begin
                    e_done[k] = 1;
                    m_last[k] = m_owner[k];
                    m_beats[k] = 0;
                    if (v != 0) m_owner[k] = rr_next(m_owner[k], v);
                    else        m_active[k] = 0;
                end
            end else if (m_beats[k] == 0) begin
                m_active[k] = 0;
            end else if (timeout_of[k] > 0) begin
                if (m_stall[k] == timeout_of[k]) begin
                    m_pad[k] = 1;
                    m_stall[k] = 0;
                end else begin
                    m_stall[k]++;
                end
            end
        end else if (v != 0) begin
            m_owner[k] = rr_next(m_last[k], v);
            m_active[k] = 1;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- compare, word collection, queue pops ----------------
    word_t       wq0 [$];
    word_t       wq1 [$];
    int          nbeats [2];
    int          acnt   [2];
    logic [31:0] acc    [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d req_ready", k), rdy[k], exp_ready(k));
            check($sformatf("k%0d pk_valid", k), pkv[k], e_v[k]);
            if (e_v[k]) check($sformatf("k%0d pk_data", k), pkd[k], e_d[k]);
            check($sformatf("k%0d word_owner", k), wo[k], e_o[k]);
            check($sformatf("k%0d word_done", k), wd[k], e_done[k]);
            check($sformatf("k%0d word_padded", k), wp[k], e_pd[k]);

            if (!rst_n) begin
                acnt[k] = 0; acc[k] = '0; nbeats[k] = 0;
                if (k == 0) wq0.delete(); else wq1.delete();
            end else if (pkv[k]) begin
                nbeats[k]++;
                if (acnt[k] < RATIO) acc[k][acnt[k]*SI +: SI] = pkd[k];
                acnt[k]++;
                if (wd[k]) begin
                    word_t w;
                    w.owner = int'(wo[k]); w.data = acc[k];
                    w.padded = wp[k]; w.cyc = cyc;
                    if (k == 0) wq0.push_back(w); else wq1.push_back(w);
                    acnt[k] = 0; acc[k] = '0;
                end
            end

            for (int i = 0; i < N; i++)
                if (rst_n && rdy[k][i] && vld[k][i]) hd[k][i]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_queues();
        en[0] = '1;
        en[1] = '1;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_beats(input int k, input int n, input int maxc, input string tag);
        int c;
        c = 0;
        @(negedge clk); #1;
        while (nbeats[k] < n && c < maxc) begin
            @(negedge clk); #1;
            c++;
        end
        check({tag, " beats reached"}, nbeats[k] >= n, 1);
    endtask

    task automatic wait_words(input int k, input int n, input int maxc, input string tag);
        int c;
        c = 0;
        @(negedge clk); #1;
        while (((k == 0) ? wq0.size() : wq1.size()) < n && c < maxc) begin
            @(negedge clk); #1;
            c++;
        end
        check({tag, " words reached"}, ((k == 0) ? wq0.size() : wq1.size()) >= n, 1);
    endtask

    task automatic check_word(input int k, input int idx, input int owner,
                              input logic [31:0] data, input bit padded, input string tag);
        int    sz;
        word_t w;
        sz = (k == 0) ? wq0.size() : wq1.size();
        check({tag, " present"}, sz > idx, 1);
        if (sz > idx) begin
            w = (k == 0) ? wq0[idx] : wq1[idx];
            check({tag, " owner"}, w.owner, owner);
            check({tag, " data"}, w.data, data);
            check({tag, " padded"}, w.padded, padded);
        end
    endtask

    function automatic int word_cyc(input int k, input int idx);
        if (k == 0) return (wq0.size() > idx) ? wq0[idx].cyc : -1;
        return (wq1.size() > idx) ? wq1[idx].cyc : -1;
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        vld[0] = '0; vld[1] = '0; dat[0] = '0; dat[1] = '0;
        en[0] = '1; en[1] = '1;
        clear_queues();

        // Single requester, reset values and first-word latency.
        do_reset(2);
        push_both(0, 8'h11); push_both(0, 8'h22); push_both(0, 8'h33); push_both(0, 8'h44);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d reset ready", k), rdy[k], 4'b0000);
            check($sformatf("k%0d reset pk_valid", k), pkv[k], 1'b0);
            check($sformatf("k%0d reset owner", k), wo[k], 2'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d grant ready", k), rdy[k], 4'b0001);
            check($sformatf("k%0d bubble pk_valid", k), pkv[k], 1'b0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d first beat valid", k), pkv[k], 1'b1);
            check($sformatf("k%0d first beat data", k), pkd[k], 8'h11);
        end
        for (int k = 0; k < 2; k++) begin
            wait_words(k, 1, 40, $sformatf("k%0d single", k));
            check_word(k, 0, 0, 32'h44332211, 1'b0, $sformatf("k%0d single w0", k));
        end

        // All requesters continuously valid: rotation with no bubbles.
        do_reset(2);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < RATIO; j++) push_both(i, 8'(16 * (i + 1) + j));
        for (int k = 0; k < 2; k++) begin
            wait_words(k, 4, 80, $sformatf("k%0d rr", k));
            for (int i = 0; i < N; i++) begin
                logic [7:0] b0, b1, b2, b3;
                b0 = 8'(16 * (i + 1)); b1 = b0 + 8'd1; b2 = b0 + 8'd2; b3 = b0 + 8'd3;
                check_word(k, i, i, {b3, b2, b1, b0}, 1'b0, $sformatf("k%0d rr w%0d", k, i));
                if (i > 0)
                    check($sformatf("k%0d rr spacing w%0d", k, i),
                          word_cyc(k, i) - word_cyc(k, i - 1), 4);
            end
        end

        // Owner 2 stalls after two beats; req 0 waits behind it.
        do_reset(2);
        push_both(2, 8'hA1); push_both(2, 8'hA2);
        wait_beats(0, 2, 40, "stall first beats");
        for (int j = 1; j <= 4; j++) push_both(0, 8'(j));
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("k0 stall edge16 ready", rdy[0], 4'b0100);
        check("k0 stall edge16 pk_valid", pkv[0], 1'b0);
        @(negedge clk);
        check("k0 pad state ready", rdy[0], 4'b0000);
        check("k1 stall ready", rdy[1], 4'b0100);
        @(negedge clk);
        check("k0 pad beat valid", pkv[0], 1'b1);
        check("k0 pad beat data", pkd[0], 8'h00);
        check("k0 pad beat not done", wd[0], 1'b0);
        @(negedge clk);
        check("k0 pad done", wd[0], 1'b1);
        check("k0 pad padded", wp[0], 1'b1);
        check("k0 pad owner", wo[0], 2'd2);
        repeat (80) @(posedge clk);
        #1;
        check("k1 long stall ready", rdy[1], 4'b0100);
        push_both(2, 8'hA3); push_both(2, 8'hA4);
        wait_words(0, 3, 200, "k0 stall");
        wait_words(1, 2, 200, "k1 stall");
        check_word(0, 0, 2, 32'h0000A2A1, 1'b1, "k0 stall w0");
        check_word(0, 1, 0, 32'h04030201, 1'b0, "k0 stall w1");
        check_word(0, 2, 2, 32'h0000A4A3, 1'b1, "k0 stall w2");
        check_word(1, 0, 2, 32'hA4A3A2A1, 1'b0, "k1 stall w0");
        check_word(1, 1, 0, 32'h04030201, 1'b0, "k1 stall w1");

        // Accept on the exact timeout edge beats the pad decision.
        do_reset(2);
        push_both(1, 8'hB1); push_both(1, 8'hB2);
        wait_beats(0, 2, 40, "boundary first beats");
        repeat (16) @(posedge clk);
        #1;
        push_both(1, 8'hB3); push_both(1, 8'hB4);
        for (int k = 0; k < 2; k++) begin
            wait_words(k, 1, 40, $sformatf("k%0d boundary", k));
            check_word(k, 0, 1, 32'hB4B3B2B1, 1'b0, $sformatf("k%0d boundary w0", k));
        end

        // Reset in the middle of a word from req 1.
        do_reset(2);
        push_both(1, 8'hC1); push_both(1, 8'hC2); push_both(1, 8'hC3); push_both(1, 8'hC4);
        wait_beats(0, 1, 40, "midreset first beat");
        rst_n = 1'b0;
        clear_queues();
        push_both(0, 8'hD1); push_both(0, 8'hD2); push_both(0, 8'hD3); push_both(0, 8'hD4);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d midreset ready", k), rdy[k], 4'b0000);
            check($sformatf("k%0d midreset pk_valid", k), pkv[k], 1'b0);
            check($sformatf("k%0d midreset pk_data", k), pkd[k], 8'h00);
            check($sformatf("k%0d midreset done", k), wd[k], 1'b0);
            check($sformatf("k%0d midreset padded", k), wp[k], 1'b0);
            check($sformatf("k%0d midreset owner", k), wo[k], 2'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_words(k, 1, 40, $sformatf("k%0d midreset", k));
            check_word(k, 0, 0, 32'hD4D3D2D1, 1'b0, $sformatf("k%0d midreset w0", k));
        end

        // Req 3 granted then withdraws before any beat.
        do_reset(2);
        push_both(3, 8'hE1);
        @(posedge clk); #1;
        en[0][3] = 1'b0;
        en[1][3] = 1'b0;
        push_both(0, 8'hF1); push_both(0, 8'hF2); push_both(0, 8'hF3); push_both(0, 8'hF4);
        @(negedge clk);
        for (int k = 0; k < 2; k++) check($sformatf("k%0d withdraw grant", k), rdy[k], 4'b1000);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d withdraw release", k), rdy[k], 4'b0000);
            check($sformatf("k%0d withdraw no beat", k), pkv[k], 1'b0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) check($sformatf("k%0d withdraw regrant", k), rdy[k], 4'b0001);
        for (int k = 0; k < 2; k++) begin
            wait_words(k, 1, 40, $sformatf("k%0d withdraw", k));
            check_word(k, 0, 0, 32'hF4F3F2F1, 1'b0, $sformatf("k%0d withdraw w0", k));
            check($sformatf("k%0d withdraw beat count", k), nbeats[k], 4);
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
